// File: rtl/video_pkg.sv
// video_pkg: shared encodings, default timing thresholds and small helpers
// for the video mode controller and its sub-blocks.
package video_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_15K  = 2'b01,
    MODE_31K  = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'b00,
    ST_MEASURE = 2'b01,
    ST_LOCKED  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CLS_BAD = 2'b00,
    CLS_15K = 2'b01,
    CLS_31K = 2'b10
  } class_e;

  typedef enum logic [1:0] {
    SCAN_NONE = 2'b00,
    SCAN_25   = 2'b01,
    SCAN_50   = 2'b10,
    SCAN_75   = 2'b11
  } scan_e;

  // Line periods are in clk_x2 cycles: 2048 nominal for 15 kHz, 1024 for 31 kHz, +-10%.
  localparam int unsigned DEF_L15_MIN    = 1843;
  localparam int unsigned DEF_L15_MAX    = 2253;
  localparam int unsigned DEF_L31_MIN    = 922;
  localparam int unsigned DEF_L31_MAX    = 1126;
  localparam int unsigned DEF_LOCK_LINES = 16;
  localparam int unsigned DEF_LOST_LINES = 4;
  localparam int unsigned DEF_DEBOUNCE   = 65535;

  localparam logic [11:0] PC_MAX = 12'hFFF;
  localparam logic [10:0] LC_MAX = 11'h7FF;

  // Classify a measured line period against the two acceptance windows.
  function automatic class_e classify(input logic [11:0] pc,
                                      input logic [11:0] lo15,
                                      input logic [11:0] hi15,
                                      input logic [11:0] lo31,
                                      input logic [11:0] hi31);
    class_e c;
    if ((pc >= lo15) && (pc <= hi15)) begin
      c = CLS_15K;
    end else if ((pc >= lo31) && (pc <= hi31)) begin
      c = CLS_31K;
    end else begin
      c = CLS_BAD;
    end
    return c;
  endfunction

  // Map a line class onto the externally visible mode encoding.
  function automatic mode_e cls_to_mode(input class_e c);
    mode_e m;
    case (c)
      CLS_15K: m = MODE_15K;
      CLS_31K: m = MODE_31K;
      default: m = MODE_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: two-flop synchronizer followed by a stable-state counter.
// The stable state resets high so a button held through reset never
// produces a rising edge until it has been released and pressed again.
module sync_debounce #(
  parameter int unsigned DEBOUNCE = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE - 1);

  logic        s1_r;
  logic        s2_r;
  logic        stable_r;
  logic        rise_r;
  logic [15:0] cnt_r;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
    end
  end

  // Accept a new level only after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_r <= 1'b1;
      cnt_r    <= 16'd0;
      rise_r   <= 1'b0;
    end else if (s2_r != stable_r) begin
      if (cnt_r == CNT_LAST) begin
        stable_r <= s2_r;
        cnt_r    <= 16'd0;
        rise_r   <= s2_r;
      end else begin
        cnt_r  <= cnt_r + 16'd1;
        rise_r <= 1'b0;
      end
    end else begin
      cnt_r  <= 16'd0;
      rise_r <= 1'b0;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: measures the input hsync period and lines per frame,
// classifies 15/31 kHz timing, locks on stable input and configures the
// scandoubler (bypass and user scanline intensity).
module video_mode_ctrl
  import video_pkg::*;
#(
  parameter int unsigned L15_MIN    = DEF_L15_MIN,
  parameter int unsigned L15_MAX    = DEF_L15_MAX,
  parameter int unsigned L31_MIN    = DEF_L31_MIN,
  parameter int unsigned L31_MAX    = DEF_L31_MAX,
  parameter int unsigned LOCK_LINES = DEF_LOCK_LINES,
  parameter int unsigned LOST_LINES = DEF_LOST_LINES,
  parameter int unsigned DEBOUNCE   = DEF_DEBOUNCE
) (
  input  logic        clk_x2,
  input  logic        reset_n,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        btn_scan,
  input  logic        force_bypass,
  output logic        scandoubler_disable,
  output logic [1:0]  scanlines,
  output logic        locked,
  output logic [1:0]  mode,
  output logic [11:0] line_period,
  output logic [10:0] frame_lines,
  output logic        mode_chg
);

  localparam logic [11:0] L15_MIN_V = 12'(L15_MIN);
  localparam logic [11:0] L15_MAX_V = 12'(L15_MAX);
  localparam logic [11:0] L31_MIN_V = 12'(L31_MIN);
  localparam logic [11:0] L31_MAX_V = 12'(L31_MAX);
  localparam logic [7:0]  LOCK_V    = 8'(LOCK_LINES);
  localparam logic [7:0]  LOST_V    = 8'(LOST_LINES);

  logic        hs_s1_r, hs_s2_r, hs_d_r;
  logic        vs_s1_r, vs_s2_r, vs_d_r;
  logic        hs_fall_s, vs_fall_s;
  logic [11:0] pc_r, line_period_r;
  logic [10:0] lc_r, frame_lines_r, lc_inc_s;
  logic        timeout_s;
  class_e      cls_s, cls_r, cls_nxt;
  state_e      state_r, state_nxt;
  logic [7:0]  run_r, run_nxt, run_inc_s;
  logic [7:0]  miss_r, miss_nxt, miss_inc_s;
  mode_e       mode_r, mode_d_r, mode_nxt;
  logic        locked_r, locked_nxt, mode_chg_r;
  logic        sd_mode_r, sd_mode_nxt, disable_r, disable_nxt;
  logic [1:0]  setting_r, scan_r, scan_nxt;
  logic        btn_rise_s;

  sync_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_btn (
    .clk    (clk_x2),
    .reset_n(reset_n),
    .din    (btn_scan),
    .rise   (btn_rise_s)
  );

  // Synchronize hs/vs and keep one delayed copy for falling-edge detection.
  always_ff @(posedge clk_x2) begin
    if (!reset_n) begin
      hs_s1_r <= 1'b1;
      hs_s2_r <= 1'b1;
      hs_d_r  <= 1'b1;
      vs_s1_r <= 1'b1;
      vs_s2_r <= 1'b1;
      vs_d_r  <= 1'b1;
    end else begin
      hs_s1_r <= hs_in;
      hs_s2_r <= hs_s1_r;
      hs_d_r  <= hs_s2_r;
      vs_s1_r <= vs_in;
      vs_s2_r <= vs_s1_r;
      vs_d_r  <= vs_s2_r;
    end
  end

  assign hs_fall_s  = hs_d_r & ~hs_s2_r;
  assign vs_fall_s  = vs_d_r & ~vs_s2_r;
  assign cls_s      = classify(pc_r, L15_MIN_V, L15_MAX_V, L31_MIN_V, L31_MAX_V);
  assign timeout_s  = (pc_r == PC_MAX) && !hs_fall_s;
  assign run_inc_s  = run_r + 8'd1;
  assign miss_inc_s = miss_r + 8'd1;
  assign lc_inc_s   = (lc_r == LC_MAX) ? lc_r : (lc_r + 11'd1);

  // Saturating line period counter; an hs edge publishes and restarts it.
  always_ff @(posedge clk_x2) begin
    if (!reset_n) begin
      pc_r          <= 12'd0;
      line_period_r <= 12'd0;
    end else if (hs_fall_s) begin
      line_period_r <= pc_r;
      pc_r          <= 12'd1;
    end else if (pc_r != PC_MAX) begin
      pc_r <= pc_r + 12'd1;
    end
  end

  // Count hs edges per frame; an hs edge coinciding with vs closes the old frame.
  always_ff @(posedge clk_x2) begin
    if (!reset_n) begin
      lc_r          <= 11'd0;
      frame_lines_r <= 11'd0;
    end else if (vs_fall_s) begin
      frame_lines_r <= hs_fall_s ? lc_inc_s : lc_r;
      lc_r          <= 11'd0;
    end else if (hs_fall_s) begin
      lc_r <= lc_inc_s;
    end
  end

  // Lock FSM state register together with its run/miss/class bookkeeping.
  always_ff @(posedge clk_x2) begin
    if (!reset_n) begin
      state_r <= ST_SEARCH;
      run_r   <= 8'd0;
      miss_r  <= 8'd0;
      cls_r   <= CLS_BAD;
    end else begin
      state_r <= state_nxt;
      run_r   <= run_nxt;
      miss_r  <= miss_nxt;
      cls_r   <= cls_nxt;
    end
  end

  // Lock FSM next state: build a run of same-class lines, tolerate a few misses.
  always_comb begin
    state_nxt = state_r;
    run_nxt   = run_r;
    miss_nxt  = miss_r;
    cls_nxt   = cls_r;
    case (state_r)
      ST_SEARCH: begin
        if (hs_fall_s && (cls_s != CLS_BAD)) begin
          state_nxt = ST_MEASURE;
          run_nxt   = 8'd1;
          cls_nxt   = cls_s;
        end else begin
          state_nxt = ST_SEARCH;
        end
      end
      ST_MEASURE: begin
        if (hs_fall_s) begin
          if (cls_s == CLS_BAD) begin
            state_nxt = ST_SEARCH;
            run_nxt   = 8'd0;
          end else if (cls_s != cls_r) begin
            state_nxt = ST_MEASURE;
            run_nxt   = 8'd1;
            cls_nxt   = cls_s;
          end else if (run_inc_s == LOCK_V) begin
            state_nxt = ST_LOCKED;
            run_nxt   = run_inc_s;
            miss_nxt  = 8'd0;
          end else begin
            state_nxt = ST_MEASURE;
            run_nxt   = run_inc_s;
          end
        end else if (timeout_s) begin
          state_nxt = ST_SEARCH;
          run_nxt   = 8'd0;
        end else begin
          state_nxt = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (hs_fall_s) begin
          if (cls_s == cls_r) begin
            state_nxt = ST_LOCKED;
            miss_nxt  = 8'd0;
          end else if (miss_inc_s == LOST_V) begin
            state_nxt = ST_SEARCH;
            miss_nxt  = 8'd0;
            run_nxt   = 8'd0;
          end else begin
            state_nxt = ST_LOCKED;
            miss_nxt  = miss_inc_s;
          end
        end else if (timeout_s) begin
          state_nxt = ST_SEARCH;
          miss_nxt  = 8'd0;
          run_nxt   = 8'd0;
        end else begin
          state_nxt = ST_LOCKED;
        end
      end
      default: begin
        state_nxt = ST_SEARCH;
        run_nxt   = 8'd0;
        miss_nxt  = 8'd0;
        cls_nxt   = CLS_BAD;
      end
    endcase
  end

  // Output decode: mode follows the lock, bypass holds its last value while no mode is known.
  always_comb begin
    locked_nxt = (state_nxt == ST_LOCKED);
    if (state_nxt == ST_LOCKED) begin
      mode_nxt = cls_to_mode(cls_nxt);
    end else begin
      mode_nxt = MODE_NONE;
    end
    case (mode_r)
      MODE_15K: sd_mode_nxt = 1'b0;
      MODE_31K: sd_mode_nxt = 1'b1;
      default:  sd_mode_nxt = sd_mode_r;
    endcase
    disable_nxt = force_bypass | sd_mode_nxt;
    if (disable_nxt) begin
      scan_nxt = SCAN_NONE;
    end else begin
      scan_nxt = setting_r;
    end
  end

  // Registered outputs; mode_chg flags a mode change one cycle after it happens.
  always_ff @(posedge clk_x2) begin
    if (!reset_n) begin
      locked_r   <= 1'b0;
      mode_r     <= MODE_NONE;
      mode_d_r   <= MODE_NONE;
      mode_chg_r <= 1'b0;
      sd_mode_r  <= 1'b0;
      disable_r  <= 1'b0;
      scan_r     <= SCAN_NONE;
    end else begin
      locked_r   <= locked_nxt;
      mode_r     <= mode_nxt;
      mode_d_r   <= mode_r;
      mode_chg_r <= (mode_r != mode_d_r);
      sd_mode_r  <= sd_mode_nxt;
      disable_r  <= disable_nxt;
      scan_r     <= scan_nxt;
    end
  end

  // User scanline setting steps on each debounced press, wrapping 11 -> 00.
  always_ff @(posedge clk_x2) begin
    if (!reset_n) begin
      setting_r <= SCAN_NONE;
    end else if (btn_rise_s) begin
      setting_r <= setting_r + 2'd1;
    end
  end

  assign scandoubler_disable = disable_r;
  assign scanlines           = scan_r;
  assign locked              = locked_r;
  assign mode                = mode_r;
  assign line_period         = line_period_r;
  assign frame_lines         = frame_lines_r;
  assign mode_chg            = mode_chg_r;

endmodule
